rr_burst_arbiter: RTL and testbench
===================================

# rr_burst_arbiter

Registered round-robin arbiter that shares one downstream resource among N requesters. A grant is held for a multi-cycle burst and released on a last-beat indication, on request withdrawal, or on burst-length expiry. The block is the multi-cycle, fairness-enforcing companion to the single-cycle arbiter and sits between requester ports and a shared bus or memory port.

## Interface
- `N`, default 32: number of requesters; legal for N ≥ 1.
- `MAX_BURST`, default 8: maximum number of cycles one grant may be held; legal for MAX_BURST ≥ 1.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req_i`  input  N  request per requester; the requester holds it high until its burst completes.
- `last_i`  input  1  final-beat indication from the currently granted requester; ignored when `gnt_valid_o` = 0.
- `gnt_o`  output  N  one-hot grant; registered.
- `gnt_id_o`  output  max(1,$clog2(N))  binary index of the granted requester; registered.
- `gnt_valid_o`  output  1  high whenever `gnt_o` is non-zero.

## Operation
- State: FSM {IDLE, BUSY}, round-robin pointer `ptr` (0..N-1), and burst counter `cnt` of width $clog2(MAX_BURST+1).
- Reset (`reset` = 0 at an edge) sets:
  - `gnt_o` = 0, `gnt_id_o` = 0, `gnt_valid_o` = 0.
  - `ptr` = 0, `cnt` = 0, state IDLE.
  - Reset dominates every other input, including mid-burst.
- Arbitration function: the winner is the first index i with `req_i[i]` = 1, searching `ptr`, `ptr`+1, … with wrap-around modulo N. No request means no winner.
- IDLE:
  - If a winner exists, on the next edge set `gnt_o` = onehot(winner), `gnt_id_o` = winner, `cnt` = 1, and go to BUSY.
  - Otherwise remain in IDLE.
- BUSY: each cycle, evaluate `rel` = ~`req_i[gnt_id_o]` | `last_i` | (`cnt` == MAX_BURST).
  - If `rel` = 0: keep the grant and increment `cnt`.
  - If `rel` = 1:
    - Set `ptr` = (`gnt_id_o`+1) mod N.
    - Arbitrate on the current `req_i` using the new pointer value.
    - If a winner exists, grant it on the next edge with no idle bubble and `cnt` = 1, staying in BUSY.
    - Otherwise clear the grant outputs and go to IDLE.
- Fairness: the just-released requester wins again only if no other requester is active. A sole requester is re-granted back-to-back with `cnt` restarted.
- N = 1: `ptr` is constantly 0 and `gnt_id_o` is constantly 0.
- MAX_BURST = 1: every grant lasts exactly one cycle, so active requesters rotate every cycle.
- `gnt_o` is always one-hot or zero, and `gnt_valid_o` = |`gnt_o`.

## Timing
- Latency from request to grant is 1 cycle: a request sampled at edge k while IDLE produces `gnt_o` high from edge k onward (visible in cycle k+1).
- Outputs are driven purely from registers, with no combinational path from inputs to outputs.
- Grant duration with the request held and `last_i` low is exactly MAX_BURST cycles.
- `last_i` high in grant cycle j: the grant lasts j cycles.
- Request withdrawal: if `req_i[gnt_id_o]` falls in cycle j, the grant remains high in cycle j and drops (or moves) at the end of cycle j. One grant cycle with no request is expected; requesters must tolerate it.
- Hand-over is back-to-back with zero dead cycles when another request is pending.
- Simultaneous events: any combination of `last_i`, request drop, and expiry in the same cycle produces a single release. New requests arriving in the release cycle participate in that arbitration.
- Mid-burst reset: the grant is gone in the cycle after the reset edge. The first grant after reset is released follows the `ptr` = 0 ordering.

## Test plan
- N=4, MAX_BURST=4. Hold `reset` low for 3 cycles with `req_i`=4'b1111 -> `gnt_o`=0 throughout. Release reset -> `gnt_o`=4'b0001 one cycle later.
- `req_i`=4'b1111 held, `last_i`=0 -> `gnt_o` sequence 0001×4, 0010×4, 0100×4, 1000×4, 0001, with no zero cycles between grants.
- `req_i`=4'b0101, `last_i` pulsed in the 2nd grant cycle of requester 0 -> 0001×2, then 0100×4, then 0001.
- Only `req_i[2]` held -> `gnt_o`=0100 continuously, `gnt_id_o`=2, and `cnt` cycles 1..4 repeatedly.
- Requester 0 granted, `req_i[0]` dropped in grant cycle 2 with no other requests -> `gnt_o`=0001 for 2 cycles, then 0 with `gnt_valid_o`=0. `req_i`=4'b0011 then -> grant goes to requester 1 (`ptr`=1).
- `reset` pulled low in grant cycle 2 of requester 3 -> `gnt_o`=0 on the next cycle. After reset is released with `req_i`=4'b1001 -> requester 0 wins.

Source files
------------

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: registered round-robin arbiter with burst-length grants.
// A grant is held until the owner signals last beat, withdraws its request,
// or the burst counter reaches MAX_BURST; hand-over is back-to-back.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no grant outstanding; arbitrate from ptr every cycle
// S_BUSY | grant held by gnt_id_o; on release re-arbitrate from owner+1
module rr_burst_arbiter #(
    parameter int N         = 32,
    parameter int MAX_BURST = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N-1:0]                     req_i,
    input  logic                             last_i,
    output logic [N-1:0]                     gnt_o,
    output logic [(N > 1 ? $clog2(N) : 1)-1:0] gnt_id_o,
    output logic                             gnt_valid_o
);

    localparam int IDW = (N > 1) ? $clog2(N) : 1;
    localparam int CW  = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [N-1:0]   gnt_nxt;
    logic [IDW-1:0] id_nxt;

    logic           rel;
    int             rel_base;
    int             arb_base;
    logic [IDW:0]   arb;
    logic           arb_found;
    logic [IDW-1:0] arb_id;

    // First requester at or after base (with wrap); MSB flags a winner.
    // Scanning from the far end lets the nearest offset overwrite the result.
    function automatic logic [IDW:0] arbitrate(input logic [N-1:0] req, input int base);
        logic [IDW:0] res;
        int           idx;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = base + k;
            if (idx >= N) idx = idx - N;
            if (req[IDW'(idx)]) res = {1'b1, IDW'(idx)};
        end
        return res;
    endfunction

    // Release condition of the current burst and the pointer the arbiter uses.
    assign rel       = ~req_i[gnt_id_o] | last_i | (cnt == CW'(MAX_BURST));
    assign rel_base  = (int'(gnt_id_o) >= N - 1) ? 0 : int'(gnt_id_o) + 1;
    assign arb_base  = (state == S_BUSY) ? rel_base : int'(ptr);
    assign arb       = arbitrate(req_i, arb_base);
    assign arb_found = arb[IDW];
    assign arb_id    = arb[IDW-1:0];

    assign gnt_valid_o = |gnt_o;

    // State and output registers; reset wins over everything, even mid-burst.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= S_IDLE;
            ptr      <= '0;
            cnt      <= '0;
            gnt_o    <= '0;
            gnt_id_o <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            gnt_o    <= gnt_nxt;
            gnt_id_o <= id_nxt;
        end
    end

    // Next-state: leave IDLE on any winner, leave BUSY only on an empty release.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (arb_found) state_nxt = S_BUSY;
            S_BUSY: if (rel && !arb_found) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next grant, burst count and pointer.
    always_comb begin
        gnt_nxt = gnt_o;
        id_nxt  = gnt_id_o;
        cnt_nxt = cnt;
        ptr_nxt = ptr;
        unique case (state)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_nxt = N'(1) << arb_id;
                    id_nxt  = arb_id;
                    cnt_nxt = CW'(1);
                end
            end
            S_BUSY: begin
                if (!rel) begin
                    cnt_nxt = cnt + CW'(1);
                end else begin
                    ptr_nxt = IDW'(rel_base);
                    if (arb_found) begin
                        gnt_nxt = N'(1) << arb_id;
                        id_nxt  = arb_id;
                        cnt_nxt = CW'(1);
                    end else begin
                        gnt_nxt = '0;
                        id_nxt  = '0;
                        cnt_nxt = '0;
                    end
                end
            end
            default: begin
                gnt_nxt = '0;
                id_nxt  = '0;
                cnt_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Testbench for rr_burst_arbiter: directed vector table for N=4/MAX_BURST=4
// followed by random traffic checked against a behavioural model, with a
// second N=3/MAX_BURST=1 instance sharing the stimulus.
module tb_rr_burst_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req_i;
    logic       last_i;

    logic [3:0] gnt_a;
    logic [1:0] id_a;
    logic       valid_a;
    logic [2:0] gnt_b;
    logic [1:0] id_b;
    logic       valid_b;

    rr_burst_arbiter #(.N(4), .MAX_BURST(4)) u_dut (
        .clk(clk), .reset(reset), .req_i(req_i), .last_i(last_i),
        .gnt_o(gnt_a), .gnt_id_o(id_a), .gnt_valid_o(valid_a)
    );

    rr_burst_arbiter #(.N(3), .MAX_BURST(1)) u_dut_b (
        .clk(clk), .reset(reset), .req_i(req_i[2:0]), .last_i(last_i),
        .gnt_o(gnt_b), .gnt_id_o(id_b), .gnt_valid_o(valid_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       last;
        logic [3:0] gnt;
        int         id;
        int         cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model: owner index (-1 = none), pointer, cycles held so far.
    int m_owner[2] = '{-1, -1};
    int m_ptr[2]   = '{0, 0};
    int m_len[2]   = '{0, 0};
    int m_n[2]     = '{4, 3};
    int m_max[2]   = '{4, 1};

    function automatic void add(input logic rst, input logic [3:0] req, input logic last,
                                input logic [3:0] gnt, input int id, input int cnt);
        vec_t v;
        v.rst = rst; v.req = req; v.last = last;
        v.gnt = gnt; v.id = id; v.cnt = cnt;
        tbl.push_back(v);
    endfunction

    function automatic int search(input int n, input int start, input logic [3:0] req);
        for (int k = 0; k < n; k++) begin
            if (req[(start + k) % n]) return (start + k) % n;
        end
        return -1;
    endfunction

    task automatic model_update(input int i, input logic rst, input logic [3:0] req, input logic last);
        int w;
        if (!rst) begin
            m_owner[i] = -1; m_ptr[i] = 0; m_len[i] = 0;
        end else if (m_owner[i] < 0) begin
            w = search(m_n[i], m_ptr[i], req);
            if (w >= 0) begin
                m_owner[i] = w; m_len[i] = 1;
            end
        end else if (!req[m_owner[i]] || last || m_len[i] == m_max[i]) begin
            m_ptr[i]   = (m_owner[i] + 1) % m_n[i];
            w          = search(m_n[i], m_ptr[i], req);
            m_owner[i] = w;
            m_len[i]   = (w >= 0) ? 1 : 0;
        end else begin
            m_len[i] = m_len[i] + 1;
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] req, input logic last);
        @(negedge clk);
        reset  = rst;
        req_i  = req;
        last_i = last;
        @(posedge clk);
        model_update(0, rst, req, last);
        model_update(1, rst, {1'b0, req[2:0]}, last);
        #1;
    endtask

    task automatic check_models(input string tag);
        logic [3:0] eg;
        eg = (m_owner[0] < 0) ? 4'b0 : (4'b1 << m_owner[0]);
        cmp({tag, " a.gnt"},   32'(gnt_a),     32'(eg));
        cmp({tag, " a.id"},    32'(id_a),      (m_owner[0] < 0) ? 0 : m_owner[0]);
        cmp({tag, " a.valid"}, 32'(valid_a),   32'(m_owner[0] >= 0));
        cmp({tag, " a.cnt"},   32'(u_dut.cnt), m_len[0]);
        eg = (m_owner[1] < 0) ? 4'b0 : (4'b1 << m_owner[1]);
        cmp({tag, " b.gnt"},   32'(gnt_b),       32'(eg[2:0]));
        cmp({tag, " b.id"},    32'(id_b),        (m_owner[1] < 0) ? 0 : m_owner[1]);
        cmp({tag, " b.valid"}, 32'(valid_b),     32'(m_owner[1] >= 0));
        cmp({tag, " b.cnt"},   32'(u_dut_b.cnt), m_len[1]);
    endtask

    logic [3:0] r_req;
    logic       r_rst;
    logic       r_last;

    initial begin
        reset  = 1'b0;
        req_i  = 4'b0;
        last_i = 1'b0;

        // Reset held with all requesting, then full rotation at MAX_BURST.
        for (int k = 0; k < 3; k++) add(0, 4'hF, 0, 4'h0, 0, 0);
        for (int c = 1; c <= 4; c++) add(1, 4'hF, 0, 4'h1, 0, c);
        for (int g = 1; g < 4; g++)
            for (int c = 1; c <= 4; c++) add(1, 4'hF, 0, 4'(1 << g), g, c);
        add(1, 4'hF, 0, 4'h1, 0, 1);
        // last_i in grant cycle 2 of requester 0 with req 0101.
        add(0, 4'h0, 0, 4'h0, 0, 0);
        add(1, 4'h5, 0, 4'h1, 0, 1);
        add(1, 4'h5, 0, 4'h1, 0, 2);
        add(1, 4'h5, 1, 4'h4, 2, 1);
        for (int c = 2; c <= 4; c++) add(1, 4'h5, 0, 4'h4, 2, c);
        add(1, 4'h5, 0, 4'h1, 0, 1);
        // Sole requester 2 is re-granted back-to-back.
        add(0, 4'h0, 0, 4'h0, 0, 0);
        for (int k = 0; k < 9; k++) add(1, 4'h4, 0, 4'h4, 2, (k % 4) + 1);
        // Withdrawal in grant cycle 2, idle, then pointer moved to 1.
        add(0, 4'h0, 0, 4'h0, 0, 0);
        add(1, 4'h1, 0, 4'h1, 0, 1);
        add(1, 4'h1, 0, 4'h1, 0, 2);
        add(1, 4'h0, 0, 4'h0, 0, 0);
        add(1, 4'h0, 1, 4'h0, 0, 0);
        add(1, 4'h3, 0, 4'h2, 1, 1);
        // Expiry + last + drop together, then a request arriving in release.
        for (int c = 2; c <= 4; c++) add(1, 4'h3, 0, 4'h2, 1, c);
        add(1, 4'h1, 1, 4'h1, 0, 1);
        add(1, 4'h9, 1, 4'h8, 3, 1);
        // Mid-burst reset of requester 3; ordering restarts from 0.
        add(0, 4'h0, 0, 4'h0, 0, 0);
        add(1, 4'h8, 0, 4'h8, 3, 1);
        add(1, 4'h8, 0, 4'h8, 3, 2);
        add(0, 4'h8, 0, 4'h0, 0, 0);
        add(1, 4'h9, 0, 4'h1, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].last);
            cmp($sformatf("tbl[%0d].gnt", i),   32'(gnt_a),     32'(tbl[i].gnt));
            cmp($sformatf("tbl[%0d].id", i),    32'(id_a),      tbl[i].id);
            cmp($sformatf("tbl[%0d].valid", i), 32'(valid_a),   32'(tbl[i].gnt != 4'h0));
            cmp($sformatf("tbl[%0d].cnt", i),   32'(u_dut.cnt), tbl[i].cnt);
            check_models($sformatf("tbl[%0d]", i));
        end

        // Random traffic: sticky requests with occasional flips, last pulses, resets.
        r_req = 4'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(3) == 0) r_req[b] = ~r_req[b];
            r_rst  = ($urandom_range(60) != 0);
            r_last = ($urandom_range(5) == 0);
            step(r_rst, r_req, r_last);
            check_models($sformatf("rnd[%0d]", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
